// File: rtl/my_rst_gen_pkg.sv
// Shared types and defaults for the reset generator: FSM state encoding,
// parameter defaults and the software-reset counter width.
package my_rst_gen_pkg;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RUN     = 2'd2,
    ST_SW_HOLD = 2'd3
  } state_e;

  localparam int SYNC_STAGES_DEF    = 2;
  localparam int HOLD_CYCLES_DEF    = 16;
  localparam int SW_HOLD_CYCLES_DEF = 8;
  localparam int SW_CNT_W           = 8;

  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/my_rst_gen_sync.sv
// Reset synchronizer: asynchronously cleared chain that shifts in ones, so
// release of i_rst_n reaches o_sync after STAGES clock edges.
module my_rst_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_sync
);

  logic [STAGES-1:0] chain_r;

  // Shift chain, cleared immediately whenever the external reset asserts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      chain_r <= {STAGES{1'b0}};
    end else begin
      chain_r <= {chain_r[STAGES-2:0], 1'b1};
    end
  end

  assign o_sync = chain_r[STAGES-1];

endmodule

// File: rtl/my_rst_gen.sv
// Reset generator: synchronizes the external reset, holds the downstream
// reset for a fixed time after power-on and after each software request.
module my_rst_gen
  import my_rst_gen_pkg::*;
#(
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int HOLD_CYCLES    = HOLD_CYCLES_DEF,
  parameter int SW_HOLD_CYCLES = SW_HOLD_CYCLES_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_sw_rst_req,
  output logic                o_sync_rst,
  output logic                o_busy,
  output logic                o_rst_done,
  output logic [SW_CNT_W-1:0] o_sw_rst_cnt
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, SW_HOLD_CYCLES) + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SW_HOLD_LAST = CNT_W'(SW_HOLD_CYCLES - 1);
  localparam logic [SW_CNT_W-1:0] SW_CNT_MAX = {SW_CNT_W{1'b1}};

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("my_rst_gen: SYNC_STAGES must be at least 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
    $error("my_rst_gen: HOLD_CYCLES must be at least 1");
  end
  if (SW_HOLD_CYCLES < 1) begin : g_bad_sw_hold_cycles
    $error("my_rst_gen: SW_HOLD_CYCLES must be at least 1");
  end

  logic                sync_s;
  state_e              state_r;
  state_e              state_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_nxt_s;
  logic                sw_acc_s;
  logic                sync_rst_r;
  logic                busy_r;
  logic                rst_done_r;
  logic [SW_CNT_W-1:0] sw_cnt_r;

  my_rst_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_sync  (sync_s)
  );

  // Next-state and hold counter; a low synchronizer output always wins.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    sw_acc_s    = 1'b0;
    if (!sync_s) begin
      state_nxt_s = ST_SYNC;
      cnt_nxt_s   = {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_SYNC: begin
          state_nxt_s = ST_HOLD;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end
        ST_HOLD: begin
          if (cnt_r == HOLD_LAST) begin
            state_nxt_s = ST_RUN;
            cnt_nxt_s   = {CNT_W{1'b0}};
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (i_sw_rst_req) begin
            state_nxt_s = ST_SW_HOLD;
            cnt_nxt_s   = {CNT_W{1'b0}};
            sw_acc_s    = 1'b1;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_SW_HOLD: begin
          if (cnt_r == SW_HOLD_LAST) begin
            state_nxt_s = ST_RUN;
            cnt_nxt_s   = {CNT_W{1'b0}};
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_nxt_s = ST_SYNC;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State, counter and registered outputs derived from the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r    <= ST_SYNC;
      cnt_r      <= {CNT_W{1'b0}};
      sync_rst_r <= 1'b1;
      busy_r     <= 1'b1;
      rst_done_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      sync_rst_r <= (state_nxt_s != ST_RUN);
      busy_r     <= (state_nxt_s != ST_RUN);
      rst_done_r <= (state_nxt_s == ST_RUN) && (state_r != ST_RUN);
    end
  end

  // Saturating count of accepted software resets.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sw_cnt_r <= {SW_CNT_W{1'b0}};
    end else if (sw_acc_s && (sw_cnt_r != SW_CNT_MAX)) begin
      sw_cnt_r <= sw_cnt_r + SW_CNT_W'(1);
    end else begin
      sw_cnt_r <= sw_cnt_r;
    end
  end

  assign o_sync_rst   = sync_rst_r;
  assign o_busy       = busy_r;
  assign o_rst_done   = rst_done_r;
  assign o_sw_rst_cnt = sw_cnt_r;

endmodule

// File: tb/tb_my_rst_gen.sv
// Scoreboard bench for my_rst_gen: stimulus queues the expected edge and
// count of each o_rst_done pulse; a monitor pops and compares on each pulse.
module tb_my_rst_gen;
  import my_rst_gen_pkg::*;

  typedef struct {
    int         edge_n;
    logic [7:0] cnt;
  } exp_t;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_sw_rst_req = 1'b0;
  logic       o_sync_rst;
  logic       o_busy;
  logic       o_rst_done;
  logic [7:0] o_sw_rst_cnt;

  int   edge_cnt = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  my_rst_gen dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_sw_rst_req (i_sw_rst_req),
    .o_sync_rst   (o_sync_rst),
    .o_busy       (o_busy),
    .o_rst_done   (o_rst_done),
    .o_sw_rst_cnt (o_sw_rst_cnt)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard compare on each done pulse.
  task automatic mon_loop();
    logic prev_sync;
    exp_t e;
    prev_sync = 1'b1;
    forever begin
      @(negedge i_clk);
      check("busy_eq_sync_rst", int'(o_busy), int'(o_sync_rst));
      if (!i_rst_n) begin
        check("sync_rst_in_reset", int'(o_sync_rst), 1);
      end
      check("fall_implies_done", int'(prev_sync && !o_sync_rst), int'(prev_sync && o_rst_done));
      if (o_rst_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("done_edge", edge_cnt, e.edge_n);
          check("done_sw_cnt", int'(o_sw_rst_cnt), int'(e.cnt));
          check("done_sync_rst_low", int'(o_sync_rst), 0);
          check("done_prev_high", int'(prev_sync), 1);
        end
      end
      prev_sync = o_sync_rst;
    end
  endtask

  task automatic next_cyc();
    @(negedge i_clk);
    #1;
  endtask

  task automatic pulse_req();
    i_sw_rst_req = 1'b1;
    next_cyc();
    i_sw_rst_req = 1'b0;
  endtask

  task automatic push_exp(input int edge_n, input logic [7:0] cnt);
    exp_t e;
    e.edge_n = edge_n;
    e.cnt    = cnt;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name, input int lim);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      next_cyc();
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout, %0d done pulses still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int e;
    int j;
    fork
      mon_loop();
    join_none

    // Power-on: reset low 5 cycles, then release.
    repeat (5) next_cyc();
    check("rst_sync_rst", int'(o_sync_rst), 1);
    check("rst_busy", int'(o_busy), 1);
    check("rst_done", int'(o_rst_done), 0);
    check("rst_sw_cnt", int'(o_sw_rst_cnt), 0);
    check("rst_state", int'(dut.state_r), int'(ST_SYNC));
    e = edge_cnt;
    push_exp(e + 1 + 18, 8'd0);
    i_rst_n = 1'b1;
    // HOLD entered at edge e+3 (cnt 0); cnt==3 after edge e+6.
    while (edge_cnt < e + 6) next_cyc();
    pulse_req();
    drain("power_on", 40);
    check("po_sw_cnt", int'(o_sw_rst_cnt), 0);

    // Software reset: eight cycles of hold, count 0 -> 1.
    j = edge_cnt;
    push_exp(j + 9, 8'd1);
    pulse_req();
    check("sw_sync_rst_rise", int'(o_sync_rst), 1);
    check("sw_cnt_inc", int'(o_sw_rst_cnt), 1);
    drain("sw_reset", 20);

    // Second software reset with an ignored request at SW_HOLD cnt==2.
    j = edge_cnt;
    push_exp(j + 9, 8'd2);
    pulse_req();
    while (edge_cnt < j + 3) next_cyc();
    pulse_req();
    check("sw_ignored_cnt", int'(o_sw_rst_cnt), 2);
    drain("sw_ignored", 20);

    // Mid-hold reset at HOLD cnt==10, then full sequence again.
    i_rst_n = 1'b0;
    repeat (2) next_cyc();
    e = edge_cnt;
    i_rst_n = 1'b1;
    while (edge_cnt < e + 13) next_cyc();
    i_rst_n = 1'b0;
    #1;
    check("mid_sync_rst", int'(o_sync_rst), 1);
    check("mid_busy", int'(o_busy), 1);
    check("mid_sw_cnt", int'(o_sw_rst_cnt), 0);
    repeat (3) next_cyc();
    e = edge_cnt;
    push_exp(e + 19, 8'd0);
    i_rst_n = 1'b1;
    drain("mid_hold", 40);

    // Saturation: 261 accepted software resets.
    for (int n = 1; n <= 261; n++) begin
      logic [7:0] c;
      c = (n > 255) ? 8'd255 : n[7:0];
      j = edge_cnt;
      push_exp(j + 9, c);
      pulse_req();
      drain("saturation", 20);
    end
    check("sat_cnt", int'(o_sw_rst_cnt), 255);

    // Reset asserted in the same cycle as a request: reset wins.
    i_sw_rst_req = 1'b1;
    i_rst_n = 1'b0;
    #1;
    check("simul_state", int'(dut.state_r), int'(ST_SYNC));
    check("simul_cnt", int'(o_sw_rst_cnt), 0);
    next_cyc();
    check("simul_cnt_after_edge", int'(o_sw_rst_cnt), 0);
    check("simul_sync_rst", int'(o_sync_rst), 1);
    i_sw_rst_req = 1'b0;
    next_cyc();
    e = edge_cnt;
    push_exp(e + 19, 8'd0);
    i_rst_n = 1'b1;
    drain("simultaneous", 40);
    check("simul_final_cnt", int'(o_sw_rst_cnt), 0);

    repeat (3) next_cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
